// File: rtl/sram_pkg.sv
// Shared types, default geometry and parity helper for the SRAM array controller.
package sram_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned PAR_MAX_W  = 64;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StSense,
    StResp
  } sram_state_e;

  // Even parity; zero-extending a narrower word leaves the XOR unchanged.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sram_row_decoder.sv
// Combinational row decoder: address to one-hot wordline, all-zero when disabled.
module sram_row_decoder
  import sram_pkg::*;
#(
  parameter int unsigned  ADDR_W = ADDR_W_DEF,
  localparam int unsigned ROWS   = 2 ** ADDR_W
) (
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ROWS-1:0]   wl_o
);

  always_comb begin
    wl_o = '0;
    if (en_i) wl_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/sram_ctrl.sv
// Single-port SRAM array controller: request/response handshakes, registered array drive.
// Optional even-parity column enabled by defining SRAM_CTRL_PARITY_EN.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned  ADDR_W = ADDR_W_DEF,
  parameter int unsigned  DATA_W = DATA_W_DEF,
  localparam int unsigned ROWS   = 2 ** ADDR_W,
`ifdef SRAM_CTRL_PARITY_EN
  localparam int unsigned BL_W   = DATA_W + 1
`else
  localparam int unsigned BL_W   = DATA_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
`ifdef SRAM_CTRL_PARITY_EN
  output logic              rsp_perr,
`endif
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ROWS-1:0]   wl,
  output logic [BL_W-1:0]   bl,
  output logic [BL_W-1:0]   blb,
  output logic              read_enable,
  output logic              write_enable,
  input  logic [BL_W-1:0]   bl_sense
);

  sram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              accept;

  logic              dec_en;
  logic [ROWS-1:0]   wl_d, wl_q;
  logic [BL_W-1:0]   bl_d, bl_q, blb_d, blb_q;
  logic              re_d, re_q, we_d, we_q;
  logic              ready_d, ready_q, rsp_valid_d, rsp_valid_q;
  logic [DATA_W-1:0] rdata_q;

  assign accept  = (state_q == StIdle) && req_valid && ready_q;
  assign addr_d  = accept ? req_addr : addr_q;
  assign wdata_d = accept ? req_wdata : wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = req_we ? StWrite : StRead;
      StWrite: state_d = StIdle;
      StRead:  state_d = StSense;
      StSense: state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every array-side net leaves a flop.
  always_comb begin
    dec_en      = (state_d == StWrite) || (state_d == StRead) || (state_d == StSense);
    we_d        = (state_d == StWrite);
    re_d        = (state_d == StRead) || (state_d == StSense);
    ready_d     = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
    bl_d        = '0;
    blb_d       = '0;
    if (we_d) begin
`ifdef SRAM_CTRL_PARITY_EN
      bl_d = {even_parity(PAR_MAX_W'(wdata_d)), wdata_d};
`else
      bl_d = wdata_d;
`endif
      blb_d = ~bl_d;
    end
  end

  sram_row_decoder #(
    .ADDR_W (ADDR_W)
  ) u_row_decoder (
    .en_i   (dec_en),
    .addr_i (addr_d),
    .wl_o   (wl_d)
  );

`ifdef SRAM_CTRL_PARITY_EN
  logic perr_q;
  assign rsp_perr = perr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wl_q        <= '0;
      bl_q        <= '0;
      blb_q       <= '0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
`ifdef SRAM_CTRL_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wl_q        <= wl_d;
      bl_q        <= bl_d;
      blb_q       <= blb_d;
      re_q        <= re_d;
      we_q        <= we_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      if (state_q == StSense) begin
        rdata_q <= bl_sense[DATA_W-1:0];
`ifdef SRAM_CTRL_PARITY_EN
        perr_q  <= even_parity(PAR_MAX_W'(bl_sense));
`endif
      end
    end
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign wl           = wl_q;
  assign bl           = bl_q;
  assign blb          = blb_q;
  assign read_enable  = re_q;
  assign write_enable = we_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural bit-cell array and word-level memory model.
module tb_sram_ctrl;

  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned ROWS = 16;
`ifdef SRAM_CTRL_PARITY_EN
  localparam int unsigned BW   = DW + 1;
`else
  localparam int unsigned BW   = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [ROWS-1:0] wl;
  logic [BW-1:0] bl, blb, bl_sense;
  logic          read_enable, write_enable;
`ifdef SRAM_CTRL_PARITY_EN
  logic          rsp_perr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
`ifdef SRAM_CTRL_PARITY_EN
    .rsp_perr     (rsp_perr),
`endif
    .rsp_rdata    (rsp_rdata),
    .wl           (wl),
    .bl           (bl),
    .blb          (blb),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .bl_sense     (bl_sense)
  );

  // Bit-cell array: captures bl on the closing edge of a write, drives settled data
  // only once read_enable has been high across one edge, junk otherwise.
  logic [BW-1:0] arr [ROWS];
  logic          re_prev = 1'b0;
  logic [BW-1:0] flip;
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    re_prev <= read_enable;
    if (write_enable)
      for (int r = 0; r < ROWS; r++) if (wl[r]) arr[r] <= bl;
  end

  always_comb begin
    bl_sense = BW'(cyc * 37 + 11);
    if (read_enable && re_prev)
      for (int r = 0; r < ROWS; r++) if (wl[r]) bl_sense = arr[r] ^ flip;
  end

  logic [DW-1:0] ref_mem [ROWS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [BW-1:0] all_ones = '1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("mon_onehot", 32'($countones(wl) <= 1), 32'd1);
      check("mon_re_we_excl", 32'(read_enable & write_enable), 32'd0);
      if (write_enable) check("mon_bl_compl", 32'(bl ^ blb), 32'(all_ones));
      else              check("mon_bl_idle", 32'(bl | blb), 32'd0);
    end
  end

  // Drives a request from a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_op(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [ROWS-1:0] exp_wl, input logic [DW-1:0] exp_blb);
    send(1'b1, a, d);
    check("wr_wl", 32'(wl), 32'(exp_wl));
    check("wr_bl", 32'(bl[DW-1:0]), 32'(d));
    check("wr_blb", 32'(blb[DW-1:0]), 32'(exp_blb));
    check("wr_we", 32'(write_enable), 32'd1);
    check("wr_ready_low", 32'(req_ready), 32'd0);
`ifdef SRAM_CTRL_PARITY_EN
    check("wr_par_bit", 32'(bl[DW]), 32'(^d));
`endif
    ref_mem[a] = d;
    @(negedge clk);
    check("wr_ready_next", 32'(req_ready), 32'd1);
    check("wr_we_off", 32'(write_enable), 32'd0);
  endtask

  task automatic read_op(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int stall);
    int lat = 1;
    int re_cnt = 0;
    send(1'b0, a, '0);
    while (!rsp_valid && lat < 10) begin
      if (read_enable) re_cnt++;
      @(negedge clk);
      lat++;
    end
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_re_cycles", 32'(re_cnt), 32'd2);
    check("rd_data", 32'(rsp_rdata), 32'(exp));
    check("rd_re_off", 32'(read_enable), 32'd0);
`ifdef SRAM_CTRL_PARITY_EN
    check("rd_perr", 32'(rsp_perr), 32'(^flip));
`endif
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = a ^ 4'd1; req_wdata = 8'hEE;
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", 32'(rsp_rdata), 32'(exp));
      check("stall_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rd_done_valid", 32'(rsp_valid), 32'd0);
    check("rd_done_ready", 32'(req_ready), 32'd1);
  endtask

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [ROWS-1:0] exp_wl;
    logic [DW-1:0]   exp_blb;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [ROWS-1:0] ew;
    logic [DW-1:0]   d, eb;
    logic [AW-1:0]   a;
    bit              seen;

    vecs[0] = '{addr: 4'd3,  wdata: 8'hA5, exp_wl: 16'h0008, exp_blb: 8'h5A};
    vecs[1] = '{addr: 4'd0,  wdata: 8'h00, exp_wl: 16'h0001, exp_blb: 8'hFF};
    vecs[2] = '{addr: 4'd15, wdata: 8'hFF, exp_wl: 16'h8000, exp_blb: 8'h00};
    vecs[3] = '{addr: 4'd9,  wdata: 8'h3C, exp_wl: 16'h0200, exp_blb: 8'hC3};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; flip = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_wl", 32'(wl), 32'd0);
    check("rst_bl", 32'(bl | blb), 32'd0);
    check("rst_enables", 32'({read_enable, write_enable}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 4; i++)
      write_op(vecs[i].addr, vecs[i].wdata, vecs[i].exp_wl, vecs[i].exp_blb);
    for (int i = 0; i < 4; i++) read_op(vecs[i].addr, vecs[i].wdata, 0);

    // Reset while the read is in flight must drop it silently.
    send(1'b0, 4'd3, '0);
    check("mid_rd_re", 32'(read_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wl", 32'(wl), 32'd0);
    check("mid_rst_re", 32'(read_enable), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) check("mid_rst_ready_after", 32'(req_ready), 32'd1);
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_rst_no_rsp", 32'(seen), 32'd0);

    for (int i = 0; i < ROWS; i++) begin
      a = AW'(i); d = 8'(i) ^ 8'h3C; ew = 16'(1) << a; eb = ~d;
      write_op(a, d, ew, eb);
    end
    for (int i = 0; i < ROWS; i++) read_op(AW'(i), 8'(i) ^ 8'h3C, 0);

    // Stalled response while a write to the neighbouring row is offered.
    read_op(4'd5, ref_mem[5], 5);
    read_op(4'd4, ref_mem[4], 0);

    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(0, ROWS - 1));
      if ($urandom_range(0, 1) == 1) begin
        d = DW'($urandom); ew = 16'(1) << a; eb = ~d;
        write_op(a, d, ew, eb);
      end else begin
        read_op(a, ref_mem[a], int'($urandom_range(0, 2)));
      end
    end

`ifdef SRAM_CTRL_PARITY_EN
    write_op(4'd0, 8'h01, 16'h0001, 8'hFE);
    flip = '0;
    flip[DW] = 1'b1;
    read_op(4'd0, 8'h01, 0);
    check("perr_set", 32'(rsp_perr), 32'd1);
    flip = '0;
    read_op(4'd0, 8'h01, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Single-port controller that sits directly upstream of the SRAM bit-cell array. It accepts read/write requests on a valid/ready interface and decodes the address to a one-hot wordline. It drives complementary bitlines with write/read enables, senses the shared read bitlines, and returns read data on a valid/ready response channel. It is the only agent allowed to drive the array's WL, BL1in/BL2in, read_enable and write_enable nets.

## Interface
- ADDR_W, 4, row address width; ROWS = 2**ADDR_W wordlines
- DATA_W, 8, word width (cells per row)
- clk  in  1  array clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  row address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer accepts read data
- rsp_rdata  out  DATA_W  read data
- wl  out  ROWS  one-hot wordline (cell WL)
- bl  out  DATA_W (+1 with parity)  true write bitlines (cell BL1in)
- blb  out  DATA_W (+1 with parity)  complement write bitlines (cell BL2in)
- read_enable  out  1  array read enable
- write_enable  out  1  array write enable
- bl_sense  in  DATA_W (+1 with parity)  sensed read bitlines (cell BL1out, tri-stated when not selected)

## Operation
- States: IDLE, WRITE, READ, SENSE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch addr/we/wdata. Go to WRITE if we, else READ.
- WRITE (1 cycle): wl=onehot(addr), bl=wdata, blb=~wdata, write_enable=1. The array captures at the closing edge. Then IDLE. Writes are posted and produce no response.
- READ (1 cycle): wl=onehot(addr), read_enable=1; bitlines settle. Then SENSE.
- SENSE (1 cycle): wl and read_enable stay asserted. bl_sense is registered into rsp_rdata at the closing edge. Then RESP.
- RESP: rsp_valid=1 and rsp_rdata held stable until rsp_ready. On handshake, go to IDLE. req_ready=0 throughout.
- Outside WRITE/READ/SENSE: wl=0, read_enable=0, write_enable=0, bl=blb=0. write_enable and read_enable are never asserted together.
- bl_sense is sampled only in SENSE, so Z/X outside that window is ignored.

## Timing
- Reset values: req_ready=0 while rst_n low, and 1 from the first cycle after release. rsp_valid=0, rsp_rdata=0, wl=0, bl=0, blb=0, read_enable=0, write_enable=0, state=IDLE.
- Reset mid-operation clears every output asynchronously. The in-flight request is dropped and no response is issued.
- Write occupancy: 2 cycles, accept → WRITE. Back-to-back writes are accepted every 2nd cycle.
- Read latency: rsp_valid rises 3 cycles after the accept edge (READ, SENSE, RESP).
- Read-after-write to the same address returns the new data, because the write completes before the next accept.
- rsp_ready stalls hold RESP indefinitely, with rsp_rdata constant.
- All array-side outputs are registered, with no combinational path from req_* to wl/bl/enables.

## Configuration
- SRAM_CTRL_PARITY_EN defined:
  - One extra even-parity column is appended, and bl/blb/bl_sense are DATA_W+1 wide.
  - Writes store ^wdata in bit DATA_W.
  - In SENSE, the parity of the sensed word is checked, and an extra output rsp_perr (1 bit, reset 0) is valid alongside rsp_valid.
- Undefined: widths are DATA_W and there is no rsp_perr port.

## Structure
- Package sram_pkg holds:
  - the state enum typedef (IDLE, WRITE, READ, SENSE, RESP)
  - the default ADDR_W/DATA_W localparams
  - a parity helper function.
- Sub-module sram_row_decoder: ADDR_W → ROWS one-hot, with an enable input. It is combinational and instantiated once, with its output registered in sram_ctrl.

## Test plan
- Reset asserted mid-READ (after the accept) → wl, read_enable and rsp_valid go to 0 immediately. After release, req_ready=1 and no response ever appears.
- Write addr 3 = 0xA5 → in WRITE cycle, wl=0x0008, bl=0xA5, blb=0x5A, write_enable=1. Then req_ready=1 on the next cycle.
- Write addr 3 = 0xA5, then read addr 3 → rsp_valid 3 cycles after the read accept with rsp_rdata=0xA5. read_enable is high for exactly 2 cycles.
- Read with rsp_ready=0 for 5 cycles → rsp_valid stays 1, rsp_rdata is stable, req_ready=0, and req_valid is ignored until the handshake.
- Fill all 16 rows with addr^0x3C, then read all back → every rsp_rdata matches. wl is one-hot or zero in every cycle, and read_enable and write_enable are never high together.
- With SRAM_CTRL_PARITY_EN, write 0x01 to addr 0, force bl_sense[8] inverted during SENSE → rsp_perr=1, rsp_rdata=0x01.
